// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset and bring-up sequencer running on the PLL output clock.
// It waits for a stable PLL lock, pulses the PSRAM controller reset, waits for
// PSRAM calibration and then releases the system reset. A calibration timeout
// triggers a PLL reset pulse. Losing lock restarts the whole sequence.
//
// Ports:
//   clk          PLL output clock (single clock domain)
//   rst_n        asynchronous active-low board reset
//   pll_lock     PLL lock, asynchronous (2-FF synchronised here)
//   psram_calib  PSRAM calibration done, asynchronous (2-FF synchronised here)
//   pll_reset    active-high PLL reset request pulse
//   psram_rst_n  active-low reset to the PSRAM controller IP
//   sys_rst_n    active-low reset to cartridge/bus logic
//   ready        high while the system is running (same as sys_rst_n)
//   fail_cnt     saturating count of recoveries (timeouts + lock losses)
module pll_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned PSRAM_RST_CYCLES   = 64,
  parameter int unsigned CALIB_TIMEOUT      = 1048576,
  parameter int unsigned PLL_RST_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       psram_calib,
  output logic       pll_reset,
  output logic       psram_rst_n,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [3:0] fail_cnt
);

  localparam int unsigned MAX_AB = (LOCK_STABLE_CYCLES > PSRAM_RST_CYCLES) ?
                                   LOCK_STABLE_CYCLES : PSRAM_RST_CYCLES;
  localparam int unsigned MAX_CD = (CALIB_TIMEOUT > PLL_RST_CYCLES) ?
                                   CALIB_TIMEOUT : PLL_RST_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  // Terminal counts: the counter is zero on the first cycle in a state, so a
  // state lasting X cycles leaves when the counter shows X-1.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PSRAM_LAST  = CNT_W'(PSRAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    PSRAM_RST,
    WAIT_CALIB,
    RUN,
    PLL_RST
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             fail_inc;
  logic             timed;

  logic lock_meta;
  logic lock_s;
  logic calib_meta;
  logic calib_s;

  // Two-flop synchronisers for the asynchronous status inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      calib_meta <= 1'b0;
      calib_s    <= 1'b0;
    end else begin
      lock_meta  <= pll_lock;
      lock_s     <= lock_meta;
      calib_meta <= psram_calib;
      calib_s    <= calib_meta;
    end
  end

  // Next-state logic. Lock loss has priority in every post-lock state; in
  // WAIT_CALIB a completed calibration beats a simultaneous timeout.
  always_comb begin
    state_next = state;
    fail_inc   = 1'b0;
    timed      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) state_next = STABLE;
      end
      STABLE: begin
        timed = 1'b1;
        if (!lock_s)                 state_next = WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = PSRAM_RST;
      end
      PSRAM_RST: begin
        timed = 1'b1;
        if (!lock_s)                state_next = WAIT_LOCK;
        else if (cnt == PSRAM_LAST) state_next = WAIT_CALIB;
      end
      WAIT_CALIB: begin
        timed = 1'b1;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          fail_inc   = 1'b1;
        end else if (calib_s) begin
          state_next = RUN;
        end else if (cnt == CALIB_LAST) begin
          state_next = PLL_RST;
          fail_inc   = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
          fail_inc   = 1'b1;
        end else if (!calib_s) begin
          state_next = PSRAM_RST;
        end
      end
      PLL_RST: begin
        timed = 1'b1;
        if (cnt == PLL_LAST) state_next = WAIT_LOCK;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  // State, counter and registered outputs. Outputs are decoded from the next
  // state so they change on the same edge that enters a state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      pll_reset   <= 1'b0;
      psram_rst_n <= 1'b0;
      sys_rst_n   <= 1'b0;
      ready       <= 1'b0;
      fail_cnt    <= 4'd0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (timed) begin
        cnt <= cnt + 1'b1;
      end
      pll_reset   <= (state_next == PLL_RST);
      psram_rst_n <= (state_next == WAIT_CALIB) || (state_next == RUN);
      sys_rst_n   <= (state_next == RUN);
      ready       <= (state_next == RUN);
      if (fail_inc && (fail_cnt != 4'hF)) begin
        fail_cnt <= fail_cnt + 4'd1;
      end
    end
  end

endmodule
